// File: rtl/mdu_multicycle.sv
// mdu_multicycle: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Rev 1.0
`default_nettype none

module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  mdu_op_e          op;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;

  logic [2*WIDTH-1:0] a_sx;
  logic [2*WIDTH-1:0] b_sx;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   q_s;
  logic [WIDTH-1:0]   r_s;
  logic [WIDTH-1:0]   q_u;
  logic [WIDTH-1:0]   r_u;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign op   = mdu_op_e'(MDUOp);
  assign busy = (count != '0);

  // Low 2*WIDTH bits of an unsigned product of sign-extended operands equal the signed product.
  assign a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {ZERO, A} * {ZERO, B};

  assign q_s = $signed(A) / $signed(B);
  assign r_s = $signed(A) % $signed(B);
  assign q_u = A / B;
  assign r_u = A % B;

  always_comb begin
    res_hi = ZERO;
    res_lo = ZERO;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (B == ZERO) begin
          res_hi = A;
          res_lo = ALL_ONES;
        end else if ((A == MOST_NEG) && (B == ALL_ONES)) begin
          res_hi = ZERO;
          res_lo = A;
        end else begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      OP_DIVU: begin
        if (B == ZERO) begin
          res_hi = A;
          res_lo = ALL_ONES;
        end else begin
          res_hi = r_u;
          res_lo = q_u;
        end
      end
      default: ;
    endcase
  end

  // Result is computed at accept and parked in pend_*; the counter only models latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI      <= ZERO;
      LO      <= ZERO;
      count   <= '0;
      pend_hi <= ZERO;
      pend_lo <= ZERO;
    end else if (busy) begin
      count <= count - CW'(1);
      if (count == CW'(1)) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else if (start) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          count   <= CW'(MULT_CYCLES);
          pend_hi <= res_hi;
          pend_lo <= res_lo;
        end
        OP_DIV, OP_DIVU: begin
          count   <= CW'(DIV_CYCLES);
          pend_hi <= res_hi;
          pend_lo <= res_lo;
        end
        OP_MTHI: HI <= A;
        OP_MTLO: LO <= A;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_multicycle.sv
// tb_mdu_multicycle: directed vector bench for a 32-bit and a 16-bit mdu_multicycle.
`default_nettype none

module tb_mdu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32;
  logic        start16;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy32;
  logic [31:0] hi32;
  logic [31:0] lo32;
  logic        busy16;
  logic [15:0] hi16;
  logic [15:0] lo16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_multicycle u_dut32 (
    .clk   (clk),
    .reset (reset),
    .start (start32),
    .MDUOp (op),
    .A     (a),
    .B     (b),
    .busy  (busy32),
    .HI    (hi32),
    .LO    (lo32)
  );

  mdu_multicycle #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .start (start16),
    .MDUOp (op),
    .A     (a[15:0]),
    .B     (b[15:0]),
    .busy  (busy16),
    .HI    (hi16),
    .LO    (lo16)
  );

  typedef struct {
    string       name;
    logic        sel16;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  vec_t vecs32[10];
  vec_t vecs16[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input logic sel);
    return sel ? busy16 : busy32;
  endfunction

  function automatic logic [31:0] get_hi(input logic sel);
    return sel ? {16'h0, hi16} : hi32;
  endfunction

  function automatic logic [31:0] get_lo(input logic sel);
    return sel ? {16'h0, lo16} : lo32;
  endfunction

  task automatic run_vec(input vec_t v);
    int          n;
    logic        hold_ok;
    logic [31:0] oh;
    logic [31:0] ol;
    oh      = get_hi(v.sel16);
    ol      = get_lo(v.sel16);
    op      = v.op;
    a       = v.a;
    b       = v.b;
    start32 = !v.sel16;
    start16 = v.sel16;
    @(posedge clk); #1;
    start32 = 1'b0;
    start16 = 1'b0;
    n       = 0;
    hold_ok = 1'b1;
    while (get_busy(v.sel16) && n < 200) begin
      n++;
      if (get_hi(v.sel16) !== oh || get_lo(v.sel16) !== ol) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    check({v.name, " busy_cycles"}, 64'(n), 64'(v.cycles));
    check({v.name, " hold"}, 64'(hold_ok), 64'd1);
    check({v.name, " HI"}, 64'(get_hi(v.sel16)), 64'(v.hi));
    check({v.name, " LO"}, 64'(get_lo(v.sel16)), 64'(v.lo));
  endtask

  initial begin
    int          n;
    logic        flag;
    logic [31:0] oh;
    logic [31:0] ol;

    vecs32[0] = '{"mult_neg1x2",   1'b0, 3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs32[1] = '{"multu_ffx2",    1'b0, 3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs32[2] = '{"div_m7by2",     1'b0, 3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs32[3] = '{"divu_7by2",     1'b0, 3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs32[4] = '{"div_overflow",  1'b0, 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs32[5] = '{"divu_by0",      1'b0, 3'd4, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 10};
    vecs32[6] = '{"mult_minsq",    1'b0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs32[7] = '{"div_7bym2",     1'b0, 3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs32[8] = '{"div_by0",       1'b0, 3'd3, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 10};
    vecs32[9] = '{"multu_maxsq",   1'b0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs16[0] = '{"w16_mult",      1'b1, 3'd1, 32'h00008000, 32'h00000002, 32'h0000FFFF, 32'h00000000, 1};
    vecs16[1] = '{"w16_divu",      1'b1, 3'd4, 32'h00000009, 32'h00000004, 32'h00000001, 32'h00000002, 3};

    reset   = 1'b1;
    start32 = 1'b0;
    start16 = 1'b0;
    op      = 3'd0;
    a       = '0;
    b       = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset HI", 64'(hi32), 64'h0);
    check("reset LO", 64'(lo32), 64'h0);
    check("reset busy", 64'(busy32), 64'h0);

    // mthi then mtlo back to back; busy must never rise
    flag    = 1'b0;
    start32 = 1'b1;
    op      = 3'd5;
    a       = 32'h12345678;
    @(posedge clk); #1;
    if (busy32) flag = 1'b1;
    op = 3'd6;
    a  = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start32 = 1'b0;
    if (busy32) flag = 1'b1;
    @(posedge clk); #1;
    if (busy32) flag = 1'b1;
    check("mthi HI", 64'(hi32), 64'h12345678);
    check("mtlo LO", 64'(lo32), 64'h9ABCDEF0);
    check("mthi_mtlo busy", 64'(flag), 64'h0);

    for (int i = 0; i < 10; i++) run_vec(vecs32[i]);

    // starts issued during busy must be ignored and must not stretch busy
    oh      = hi32;
    ol      = lo32;
    start32 = 1'b1;
    op      = 3'd1;
    a       = 32'd3;
    b       = 32'd4;
    @(posedge clk); #1;
    n    = 0;
    flag = 1'b1;
    while (busy32 && n < 200) begin
      n++;
      if (hi32 !== oh || lo32 !== ol) flag = 1'b0;
      if (n == 1) begin
        start32 = 1'b1;
        op      = 3'd6;
        a       = 32'h0000DEAD;
      end else if (n == 2) begin
        op = 3'd3;
        a  = 32'd100;
        b  = 32'd7;
      end else begin
        start32 = 1'b0;
      end
      @(posedge clk); #1;
    end
    start32 = 1'b0;
    check("inject busy_cycles", 64'(n), 64'd5);
    check("inject hold", 64'(flag), 64'd1);
    check("inject HI", 64'(hi32), 64'h0);
    check("inject LO", 64'(lo32), 64'd12);
    repeat (12) begin
      @(posedge clk); #1;
      if (busy32) flag = 1'b0;
    end
    check("inject no_restart", 64'(flag && lo32 == 32'd12), 64'd1);

    // reset during busy cycle 4 of a divide aborts it
    start32 = 1'b1;
    op      = 3'd3;
    a       = 32'd100;
    b       = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    n       = 1;
    while (n < 4 && busy32) begin
      n++;
      @(posedge clk); #1;
    end
    check("abort reached_cycle4", 64'(busy32), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort HI", 64'(hi32), 64'h0);
    check("abort LO", 64'(lo32), 64'h0);
    check("abort busy", 64'(busy32), 64'h0);
    flag = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy32 || hi32 !== 32'h0 || lo32 !== 32'h0) flag = 1'b0;
    end
    check("abort no_commit", 64'(flag), 64'd1);
    run_vec('{"multu_after_abort", 1'b0, 3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5});

    // reserved and no-op codes with start asserted are ignored
    oh      = hi32;
    ol      = lo32;
    start32 = 1'b1;
    op      = 3'd7;
    a       = 32'hCAFEF00D;
    @(posedge clk); #1;
    op = 3'd0;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("reserved_op ignored", 64'({busy32, hi32 == oh, lo32 == ol}), 64'b011);

    for (int i = 0; i < 2; i++) run_vec(vecs16[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
